// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART transmitter between four requesters. A round-robin arbiter
// picks a requester while the transmitter is idle. The scheduler then writes
// that requester's byte, follows Tx_BUSY through the frame, and reports
// completion with a one-cycle done pulse.
//
// Optional feature: define UART_SCHED_TIMEOUT_EN to add a start timeout. If
// Tx_BUSY never rises within TIMEOUT_CYCLES cycles of WAIT_BUSY, the transfer
// is dropped and sched_err pulses. Without the macro, the block waits
// indefinitely and sched_err is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in WAIT_BUSY before abort (2..255)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req        in   [3:0]  per-requester transmit request
//   req_data   in   [31:0] byte for requester i on bits [8i+7:8i]
//   grant      out  [3:0]  one-hot owner of the transmitter (registered)
//   done       out  [3:0]  one-cycle pulse when the owner's byte finished
//   sched_err  out  one-cycle pulse on transmitter start timeout
//   Tx_DATA    out  [7:0]  byte presented to the transmitter
//   Tx_WR      out  one-cycle write strobe
//   Tx_EN      out  transmitter enable (high outside IDLE)
//   Tx_BUSY    in   transmitter busy, frame start to stop-bit end
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        sched_err,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_WR,
  output logic        Tx_EN,
  input  logic        Tx_BUSY
);

  // The timeout counter is 8 bits wide, so larger values cannot be honoured.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("uart_tx_scheduler: TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_served_q, last_served_d;
  logic [1:0]  win_idx_q, win_idx_d;
  logic [3:0]  grant_q, grant_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        timeout;

  // Split the packed request data into per-requester bytes.
  logic [7:0] req_byte [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_req_byte
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  // Round-robin search. Candidates are taken starting at last_served+1.
  // The 2-bit wrap makes the last-served requester the lowest priority.
  logic       rr_found;
  logic [1:0] rr_idx;
  logic [1:0] rr_cand;
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_served_q;
    rr_cand  = last_served_q;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_served_q + 2'(k);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       sched_err_q, sched_err_d;

  // The count is zero on the first WAIT_BUSY cycle.
  // It reaches TIMEOUT_CYCLES-1 on the last cycle allowed.
  assign timeout     = (state_q == WAIT_BUSY) && !Tx_BUSY &&
                       (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign wait_cnt_d  = (state_q == WAIT_BUSY) ? wait_cnt_q + 8'd1 : 8'd0;
  assign sched_err_d = timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= 8'd0;
      sched_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      sched_err_q <= sched_err_d;
    end
  end

  assign sched_err = sched_err_q;
`else
  assign timeout   = 1'b0;
  assign sched_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    win_idx_d     = win_idx_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (rr_found && !Tx_BUSY) begin
          state_d   = LOAD;
          win_idx_d = rr_idx;
          grant_d   = 4'b0001 << rr_idx;
          // Latch the byte now, so later changes on req_data cannot corrupt the frame.
          tx_data_d = req_byte[rr_idx];
        end
      end
      LOAD: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else if (timeout) begin
          state_d       = IDLE;
          last_served_d = win_idx_q;
          grant_d       = 4'b0000;
        end
      end
      WAIT_DONE: begin
        if (!Tx_BUSY) state_d = RELEASE;
      end
      RELEASE: begin
        state_d       = IDLE;
        last_served_d = win_idx_q;
        grant_d       = 4'b0000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= 2'd3;  // requester 0 wins first after reset
      win_idx_q     <= 2'd0;
      grant_q       <= 4'b0000;
      tx_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      win_idx_q     <= win_idx_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign grant   = grant_q;
  assign Tx_DATA = tx_data_q;
  assign Tx_WR   = (state_q == LOAD);
  assign Tx_EN   = (state_q != IDLE);
  assign done    = (state_q == RELEASE) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// Directed testbench for uart_tx_scheduler.
// A simple transmitter model raises Tx_BUSY on the cycle after Tx_WR and
// holds it for busy_len cycles. Some tests force Tx_BUSY directly instead.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        sched_err;
  logic [7:0]  Tx_DATA;
  logic        Tx_WR;
  logic        Tx_EN;
  logic        Tx_BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // transmitter model
  logic model_en;
  logic busy_force;
  int   busy_len;
  int   busy_cnt = 0;
  logic busy_model;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset)              busy_cnt <= 0;
    else if (Tx_WR)         busy_cnt <= busy_len;
    else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
  end
  assign busy_model = (busy_cnt != 0);
  assign Tx_BUSY    = model_en ? busy_model : busy_force;

  uart_tx_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .done      (done),
    .sched_err (sched_err),
    .Tx_DATA   (Tx_DATA),
    .Tx_WR     (Tx_WR),
    .Tx_EN     (Tx_EN),
    .Tx_BUSY   (Tx_BUSY)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Bounded wait for a done pulse. cyc is the number of cycles waited.
  task automatic wait_done(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      cyc++;
      if (done != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req        = 4'b0000;
    req_data   = 32'h0;
    model_en   = 1'b1;
    busy_force = 1'b0;
    busy_len   = 0;
    tick();
    tick();
    n_checks++;
    if ({grant, done, sched_err, Tx_DATA, Tx_WR, Tx_EN} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b done=%b err=%b data=%h wr=%b en=%b, expected all zero",
               grant, done, sched_err, Tx_DATA, Tx_WR, Tx_EN);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (Tx_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_en: got Tx_EN=%b expected 0", Tx_EN);
    end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_single();
    int cyc;
    bit ok;
    busy_len = 20;
    req_data = 32'h00A50000;
    req      = 4'b0100;
    tick();
    n_checks++;
    if ({Tx_WR, grant, Tx_DATA} !== {1'b1, 4'b0100, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_load: got wr=%b grant=%b data=%h expected wr=1 grant=0100 data=a5",
               Tx_WR, grant, Tx_DATA);
    end
    req = 4'b0000;
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != 22 || done !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_done: got done=%b after %0d cycles (seen=%0b), expected 0100 after 22",
               done, cyc, ok);
    end
    tick();
    n_checks++;
    if ({grant, done, Tx_EN} !== 9'd0) begin
      n_fail++;
      $display("FAIL single_release: got grant=%b done=%b en=%b expected all zero",
               grant, done, Tx_EN);
    end
    $display("txn single: requester 2 byte a5");
  endtask

  task automatic test_contention();
    logic [31:0] bytes;
    int          exp_order[5];
    int          done_tally[4];
    int          cyc;
    bit          ok;
    logic [3:0]  exp_oh;
    exp_order = '{0, 1, 2, 3, 0};
    done_tally = '{0, 0, 0, 0};
    bytes = 32'h44332211;
    do_reset();
    busy_len = 3;
    req_data = bytes;
    req      = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_oh = 4'b0001 << exp_order[t];
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
        tick();
        if (Tx_WR) begin
          ok = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!ok || grant !== exp_oh || Tx_DATA !== bytes[8*exp_order[t] +: 8]) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got wr_seen=%0b grant=%b data=%h expected grant=%b data=%h",
                 t, ok, grant, Tx_DATA, exp_oh, bytes[8*exp_order[t] +: 8]);
      end
      wait_done(cyc, ok);
      n_checks++;
      if (!ok || done !== exp_oh) begin
        n_fail++;
        $display("FAIL contention_done%0d: got done=%b expected %b", t, done, exp_oh);
      end
      for (int b = 0; b < 4; b++) if (done[b]) done_tally[b]++;
      tick();
      n_checks++;
      if (done !== 4'b0000) begin
        n_fail++;
        $display("FAIL contention_pulse%0d: got done=%b expected 0000", t, done);
      end
      $display("txn contention %0d: requester %0d", t, exp_order[t]);
    end
    req = 4'b0000;
    n_checks++;
    if (done_tally[0] != 2 || done_tally[1] != 1 || done_tally[2] != 1 || done_tally[3] != 1) begin
      n_fail++;
      $display("FAIL contention_tally: got %0d %0d %0d %0d expected 2 1 1 1",
               done_tally[0], done_tally[1], done_tally[2], done_tally[3]);
    end
  endtask

  task automatic test_withdrawal();
    int cyc;
    bit ok;
    busy_len = 10;
    req_data = 32'h00005A00;
    req      = 4'b0010;
    tick();
    n_checks++;
    if ({Tx_WR, grant, Tx_DATA} !== {1'b1, 4'b0010, 8'h5A}) begin
      n_fail++;
      $display("FAIL withdraw_load: got wr=%b grant=%b data=%h expected wr=1 grant=0010 data=5a",
               Tx_WR, grant, Tx_DATA);
    end
    tick();
    tick();
    req      = 4'b0000;
    req_data = 32'hFFFFFFFF;
    ok  = 1'b0;
    cyc = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      n_checks++;
      if (Tx_DATA !== 8'h5A || grant !== 4'b0010) begin
        n_fail++;
        $display("FAIL withdraw_hold: got data=%h grant=%b expected 5a 0010", Tx_DATA, grant);
      end
      if (done != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || done !== 4'b0010) begin
      n_fail++;
      $display("FAIL withdraw_done: got done=%b expected 0010", done);
    end
    req_data = 32'h0;
    tick();
    $display("txn withdrawal: requester 1 byte 5a");
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    busy_len = 20;
    req_data = 32'h000000C3;
    req      = 4'b0001;
    tick();
    n_checks++;
    if (Tx_WR !== 1'b1 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_load: got wr=%b grant=%b expected 1 0001", Tx_WR, grant);
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
    n_checks++;
    if (Tx_EN !== 1'b1 || Tx_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_inflight: got en=%b busy=%b expected 1 1", Tx_EN, Tx_BUSY);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({grant, done, sched_err, Tx_DATA, Tx_WR, Tx_EN} !== 19'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got grant=%b done=%b err=%b data=%h wr=%b en=%b expected all zero",
               grant, done, sched_err, Tx_DATA, Tx_WR, Tx_EN);
    end
    for (int c = 0; c < 25; c++) begin
      tick();
      n_checks++;
      if (done !== 4'b0000 || sched_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_nodone: got done=%b err=%b expected 0000 0", done, sched_err);
      end
    end
    req_data = 32'hD200B700;
    req      = 4'b1010;
    tick();
    n_checks++;
    if ({Tx_WR, grant, Tx_DATA} !== {1'b1, 4'b0010, 8'hB7}) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got wr=%b grant=%b data=%h expected wr=1 grant=0010 data=b7",
               Tx_WR, grant, Tx_DATA);
    end
    req = 4'b0000;
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || done !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_done: got done=%b expected 0010", done);
    end
    tick();
    $display("txn reset_mid: aborted, then requester 1 byte b7");
  endtask

  task automatic test_busy_gate();
    int cyc;
    bit ok;
    model_en   = 1'b0;
    busy_force = 1'b1;
    req_data   = 32'h00000077;
    req        = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (Tx_WR !== 1'b0 || Tx_EN !== 1'b0) begin
        n_fail++;
        $display("FAIL gate_hold: got wr=%b en=%b expected 0 0", Tx_WR, Tx_EN);
      end
    end
    busy_force = 1'b0;
    tick();
    n_checks++;
    if ({Tx_WR, grant, Tx_DATA} !== {1'b1, 4'b0001, 8'h77}) begin
      n_fail++;
      $display("FAIL gate_load: got wr=%b grant=%b data=%h expected wr=1 grant=0001 data=77",
               Tx_WR, grant, Tx_DATA);
    end
    req        = 4'b0000;
    busy_force = 1'b1;
    tick();
    tick();
    tick();
    busy_force = 1'b0;
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || done !== 4'b0001) begin
      n_fail++;
      $display("FAIL gate_done: got done=%b expected 0001", done);
    end
    tick();
    $display("txn busy_gate: requester 0 byte 77");
  endtask

  task automatic test_timeout();
    model_en   = 1'b0;
    busy_force = 1'b0;
    req_data   = 32'h6E000000;
    req        = 4'b1000;
    tick();
    n_checks++;
    if (Tx_WR !== 1'b1 || grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL timeout_load: got wr=%b grant=%b expected 1 1000", Tx_WR, grant);
    end
    req = 4'b0000;
    tick();  // first WAIT_BUSY cycle
`ifdef UART_SCHED_TIMEOUT_EN
    begin
      int cyc;
      bit ok;
      for (int k = 1; k <= 15; k++) begin
        tick();
        n_checks++;
        if (sched_err !== 1'b0 || Tx_EN !== 1'b1 || done !== 4'b0000) begin
          n_fail++;
          $display("FAIL timeout_early%0d: got err=%b en=%b done=%b expected 0 1 0000",
                   k, sched_err, Tx_EN, done);
        end
      end
      tick();
      n_checks++;
      if ({sched_err, done, grant, Tx_EN} !== {1'b1, 4'b0000, 4'b0000, 1'b0}) begin
        n_fail++;
        $display("FAIL timeout_fire: got err=%b done=%b grant=%b en=%b expected 1 0000 0000 0",
                 sched_err, done, grant, Tx_EN);
      end
      tick();
      n_checks++;
      if (sched_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_pulse: got err=%b expected 0", sched_err);
      end
      // last_served is now 3, so requester 0 outranks requester 3
      req_data = 32'h00000011;
      req      = 4'b1001;
      tick();
      n_checks++;
      if (Tx_WR !== 1'b1 || grant !== 4'b0001) begin
        n_fail++;
        $display("FAIL timeout_next: got wr=%b grant=%b expected 1 0001", Tx_WR, grant);
      end
      req        = 4'b0000;
      busy_force = 1'b1;
      tick();
      tick();
      busy_force = 1'b0;
      wait_done(cyc, ok);
      n_checks++;
      if (!ok || done !== 4'b0001) begin
        n_fail++;
        $display("FAIL timeout_recover: got done=%b expected 0001", done);
      end
      tick();
      $display("txn timeout: sched_err fired, requester 0 served next");
    end
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks++;
      if ({Tx_EN, sched_err, done} !== 6'b100000) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: got en=%b err=%b done=%b expected 1 0 0000",
                 c, Tx_EN, sched_err, done);
      end
    end
    do_reset();
    $display("txn timeout: disabled build waits in WAIT_BUSY");
`endif
    model_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_withdrawal();
    test_reset_mid();
    test_busy_gate();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles in WAIT_BUSY before abort (range 2..255).
REQ-002 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  4  per-requester transmit request, bit i = requester i.
REQ-005 The block SHALL have port req_data  input  32  byte for requester i on bits [8i+7:8i].
REQ-006 The block SHALL have port grant  output  4  one-hot, registered; requester currently owning the transmitter.
REQ-007 The block SHALL have port done  output  4  one-cycle pulse on bit i when requester i's byte has finished transmitting.
REQ-008 The block SHALL have port sched_err  output  1  one-cycle pulse on transmitter start timeout.
REQ-009 The block SHALL have port Tx_DATA  output  8  byte presented to the UART transmitter.
REQ-010 The block SHALL have port Tx_WR  output  1  one-cycle write strobe to the transmitter.
REQ-011 The block SHALL have port Tx_EN  output  1  transmitter enable.
REQ-012 The block SHALL have port Tx_BUSY  input  1  transmitter busy, high from frame start to stop-bit end.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, WAIT_BUSY, WAIT_DONE, RELEASE.
REQ-014 In IDLE with req != 0 and Tx_BUSY = 0, the FSM SHALL pick the winner round-robin, searching from last_served+1 modulo 4, and go to LOAD next cycle.
REQ-015 In IDLE with req = 0 or Tx_BUSY = 1, the FSM SHALL remain in IDLE.
REQ-016 In LOAD, grant SHALL be one-hot on the winner, Tx_DATA SHALL hold the winner's req_data byte latched at the IDLE->LOAD edge, and Tx_WR SHALL be 1 for exactly this cycle.
REQ-017 Request-to-Tx_WR latency SHALL be exactly 1 cycle (req seen in IDLE at cycle n -> Tx_WR high at cycle n+1).
REQ-018 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle Tx_BUSY = 1.
REQ-019 WAIT_DONE SHALL go to RELEASE on the first cycle Tx_BUSY = 0.
REQ-020 In RELEASE, done[winner] SHALL pulse for one cycle, grant SHALL return to 0 the next cycle, last_served SHALL update to winner, and the FSM SHALL return to IDLE.
REQ-021 Tx_DATA and grant SHALL hold stable from LOAD through RELEASE, independent of changes on req or req_data.
REQ-022 Deassertion of req[winner] after LOAD SHALL NOT abort the transfer; done SHALL still pulse.
REQ-023 Tx_EN SHALL be 1 in every state except IDLE, and 0 in IDLE.
REQ-024 If all four requests are held continuously, grants SHALL rotate 0,1,2,3,0 with no requester served twice before the others are served.
REQ-025 A requester SHALL NOT be regranted in the IDLE cycle immediately after its own RELEASE if any other req bit is set.

Reset
REQ-026 With reset = 1 at a clk edge, the FSM SHALL enter IDLE and outputs SHALL be grant=0, done=0, sched_err=0, Tx_DATA=8'h00, Tx_WR=0, Tx_EN=0.
REQ-027 Reset SHALL set last_served to 3 so requester 0 has first priority.
REQ-028 Reset asserted mid-transfer SHALL abort it without a done or sched_err pulse; reset SHALL take priority over every transition.

Configuration
REQ-029 With UART_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT_BUSY and increment each WAIT_BUSY cycle.
REQ-030 With UART_SCHED_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES without Tx_BUSY, the block SHALL pulse sched_err for one cycle, not pulse done, set last_served to the winner, clear grant, and return to IDLE.
REQ-031 Without UART_SCHED_TIMEOUT_EN, WAIT_BUSY SHALL wait indefinitely, sched_err SHALL be tied to 0, and no counter logic SHALL be built.

Verification
REQ-032 Single request: after reset, req=4'b0100 with byte 8'hA5, transmitter model busy for 20 cycles -> grant=4'b0100, Tx_WR pulse with Tx_DATA=8'hA5 one cycle after req, done=4'b0100 one cycle after Tx_BUSY falls.
REQ-033 Full contention: req=4'b1111 held for 5 transfers -> grant order 0,1,2,3,0; each done pulses exactly once per grant.
REQ-034 Withdrawal: req[1] dropped and req_data changed to 8'hFF two cycles after LOAD -> Tx_DATA stays at the original byte and done[1] still pulses.
REQ-035 Reset mid-transfer: reset pulsed in WAIT_DONE -> all outputs zero next cycle, no done pulse; next req=4'b1010 is granted to requester 1 first.
REQ-036 Timeout: macro defined, TIMEOUT_CYCLES=16, Tx_BUSY held 0 -> sched_err pulses 16 cycles after entering WAIT_BUSY, done stays 0, FSM returns to IDLE; with macro undefined, FSM stays in WAIT_BUSY.
REQ-037 Busy gate: Tx_BUSY=1 in IDLE with req=4'b0001 -> no LOAD and no Tx_WR until Tx_BUSY falls; LOAD follows on the next cycle.
